cnu_sched: RTL

CNU_SCHED -- requirements
Module: cnu_sched

---
 rtl/ldpc_pkg.sv | 15 +
 rtl/cnu_sched_if.sv | 30 +++
 rtl/wb_delay.sv | 43 ++++
 rtl/cnu_sched.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC check-node scheduler.
package ldpc_pkg;

  // Width of the completed-iteration counter.
  localparam int ITER_W = 8;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/cnu_sched_if.sv
// Handshake/bus bundle between the scheduler and its memory/CNU datapath.
interface cnu_sched_if #(
  parameter int idx_w = 8
);
  import ldpc_pkg::*;

  logic              start;
  logic              par_ok;
  logic              rd_en;
  logic [idx_w-1:0]  rd_row;
  logic              wr_en;
  logic [idx_w-1:0]  wr_row;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_cnt;

  // Controller side (drives start/par_ok, observes the schedule).
  modport master (
    output start, par_ok,
    input  rd_en, rd_row, wr_en, wr_row, busy, done, converged, iter_cnt
  );

  // Scheduler side.
  modport slave (
    input  start, par_ok,
    output rd_en, rd_row, wr_en, wr_row, busy, done, converged, iter_cnt
  );

endinterface

// File: rtl/wb_delay.sv
// LAT-deep valid+row shift register aligning write-back with the CNU result.
module wb_delay #(
  parameter int LAT   = 3,
  parameter int idx_w = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [idx_w-1:0] in_row,
  output logic             out_vld,
  output logic [idx_w-1:0] out_row
);

  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][idx_w-1:0] row_q, row_d;

  // Next-stage values: new entry at stage 0, everything else shifts by one.
  always_comb begin
    vld_d    = '0;
    row_d    = '0;
    vld_d[0] = in_vld;
    row_d[0] = in_vld ? in_row : '0;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      row_d[i] = row_q[i-1];
    end
  end

  // Pipeline registers; reset flushes in-flight write-backs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      row_q <= '0;
    end else begin
      vld_q <= vld_d;
      row_q <= row_d;
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_row = vld_q[LAT-1] ? row_q[LAT-1] : '0;

endmodule

// File: rtl/cnu_sched.sv
// Row-layered LDPC check-node scheduler: issues row reads, tracks write-back
// parity and iterates until all rows pass or the iteration limit is reached.
module cnu_sched
  import ldpc_pkg::*;
#(
  parameter int data_w   = 8,
  parameter int idx_w    = 8,
  parameter int N_ROWS   = 4,
  parameter int LAT      = 3,
  parameter int MAX_ITER = 5
) (
  input  logic        clk,
  input  logic        rst,
  cnu_sched_if.slave  bus
);

  // Reject parameter sets the schedule cannot represent.
  if (data_w < 1 || N_ROWS < 1 || N_ROWS >= (1 << idx_w) || LAT < 1 ||
      MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W)) begin : g_bad_param
    $error("cnu_sched: invalid parameter set");
  end

  localparam logic [idx_w-1:0]  ROWS_C     = idx_w'(N_ROWS);
  localparam logic [idx_w-1:0]  LAST_ROW_C = idx_w'(N_ROWS - 1);
  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [idx_w-1:0]  row_q, row_d;
  logic              rd_en_q, rd_en_d;
  logic [idx_w-1:0]  rd_row_q, rd_row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              conv_q, conv_d;
  logic              all_ok_q, all_ok_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              wr_en_s;
  logic [idx_w-1:0]  wr_row_s;

  wb_delay #(
    .LAT   (LAT),
    .idx_w (idx_w)
  ) u_wb_delay (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_en_q),
    .in_row  (rd_row_q),
    .out_vld (wr_en_s),
    .out_row (wr_row_s)
  );

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    rd_en_d  = 1'b0;
    rd_row_d = '0;
    done_d   = 1'b0;
    conv_d   = conv_q;
    iter_d   = iter_q;
    // par_ok only counts on cycles that carry a write-back.
    all_ok_d = all_ok_q & (~wr_en_s | bus.par_ok);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = ISSUE;
          rd_en_d  = 1'b1;
          rd_row_d = '0;
          row_d    = idx_w'(1);
          iter_d   = '0;
          conv_d   = 1'b0;
          all_ok_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (row_q == ROWS_C) begin
          state_d  = DRAIN;
          row_d    = '0;
        end else begin
          rd_en_d  = 1'b1;
          rd_row_d = row_q;
          row_d    = row_q + idx_w'(1);
        end
      end
      DRAIN: begin
        // Leave once the last row's write-back is on the bus this cycle.
        if (wr_en_s && (wr_row_s == LAST_ROW_C)) begin
          state_d = CHECK;
        end else begin
          state_d = DRAIN;
        end
      end
      CHECK: begin
        iter_d = iter_q + ITER_W'(1);
        if (all_ok_q || ((iter_q + ITER_W'(1)) == MAX_ITER_C)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          conv_d  = all_ok_q;
        end else begin
          // Next iteration starts immediately with row 0.
          state_d  = ISSUE;
          rd_en_d  = 1'b1;
          rd_row_d = '0;
          row_d    = idx_w'(1);
          all_ok_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      rd_en_q  <= 1'b0;
      rd_row_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
      all_ok_q <= 1'b0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rd_en_q  <= rd_en_d;
      rd_row_q <= rd_row_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      conv_q   <= conv_d;
      all_ok_q <= all_ok_d;
      iter_q   <= iter_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_row    = rd_row_q;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_row    = wr_row_s;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.converged = conv_q;
  assign bus.iter_cnt  = iter_q;

endmodule
